pc_unit: RTL and testbench

//   Parametrised program counter (R6) for the lab CPU.

---
 rtl/pc_unit_pkg.sv | 15 +
 rtl/pc_unit_ret_stack.sv | 32 +++
 rtl/pc_unit.sv | 75 +++++++
 tb/tb_pc_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: next-PC source encoding and default PC parameters
package pc_unit_pkg;
  typedef enum logic [2:0] {
    PC_SEL_RST,
    PC_SEL_HOLD,
    PC_SEL_RET,
    PC_SEL_CALL,
    PC_SEL_JMP,
    PC_SEL_BR,
    PC_SEL_INC
  } pc_sel_e;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STEP = 1;
  localparam int DEF_RESET_VEC = 0;
endpackage

// File: rtl/pc_unit_ret_stack.sv
// pc_unit_ret_stack: synchronous LIFO of return addresses; push and pop never coincide
module pc_unit_ret_stack #(
  parameter int WIDTH = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(STACK_DEPTH + 1);
  localparam int AW = $clog2(STACK_DEPTH);
  logic [WIDTH-1:0] mem [STACK_DEPTH];
  logic [PW-1:0] ptr;
  logic [AW-1:0] wr_idx, rd_idx;
  assign wr_idx = AW'(ptr);
  assign rd_idx = wr_idx - AW'(1);
  assign top = mem[rd_idx];
  assign full = ptr == PW'(STACK_DEPTH);
  assign empty = ptr == '0;
  always_ff @(posedge clk)
    if (push) mem[wr_idx] <= push_data;
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (push) ptr <= ptr + PW'(1);
    else if (pop) ptr <= ptr - PW'(1);
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with stall, branch, jump, call/return; PC_RET_STACK_EN enables the return stack
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RESET_VEC = DEF_RESET_VEC,
  parameter int STEP = DEF_STEP,
  parameter int STACK_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_off,
  input  logic             call_en,
  input  logic             ret_en,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] next_pc,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VEC);
`ifdef PC_RET_STACK_EN
  localparam logic RS = 1'b1;
`else
  localparam logic RS = 1'b0;
`endif
  pc_sel_e sel;
  logic [WIDTH-1:0] inc, ret_top;
  logic err_d;
  assign inc = pc + STEP_W;
  always_comb begin
    sel = rst ? PC_SEL_RST :
          stall ? PC_SEL_HOLD :
          (RS && ret_en) ? PC_SEL_RET :
          call_en ? PC_SEL_CALL :
          jump_en ? PC_SEL_JMP :
          branch_en ? PC_SEL_BR : PC_SEL_INC;
    next_pc = sel == PC_SEL_RST ? RST_W :
              sel == PC_SEL_HOLD ? pc :
              sel == PC_SEL_RET ? (stack_empty ? inc : ret_top) :
              (sel == PC_SEL_CALL || sel == PC_SEL_JMP) ? jump_addr :
              sel == PC_SEL_BR ? pc + branch_off : inc;
    err_d = (sel == PC_SEL_RET && stack_empty) || (sel == PC_SEL_CALL && stack_full);
  end
`ifdef PC_RET_STACK_EN
  pc_unit_ret_stack #(.WIDTH(WIDTH), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (sel == PC_SEL_CALL && !stack_full),
    .pop       (sel == PC_SEL_RET && !stack_empty),
    .push_data (inc),
    .top       (ret_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );
`else
  assign ret_top = '0;
  assign stack_full = 1'b0;
  assign stack_empty = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RST_W;
      stack_err <= 1'b0;
    end else begin
      pc <= next_pc;
      stack_err <= err_d;
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and random stimulus against a queue-based return-stack model
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst, stall, jump_en, branch_en, call_en, ret_en;
  logic [15:0] jump_addr, branch_off, pc, next_pc;
  logic stack_full, stack_empty, stack_err;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] m_pc;
  logic [15:0] m_rq[$];
`ifdef PC_RET_STACK_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif
  always #5 clk = ~clk;
  pc_unit #(.WIDTH(16), .RESET_VEC(0), .STEP(1), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump_en(jump_en), .jump_addr(jump_addr),
    .branch_en(branch_en), .branch_off(branch_off), .call_en(call_en), .ret_en(ret_en),
    .pc(pc), .next_pc(next_pc), .stack_full(stack_full), .stack_empty(stack_empty),
    .stack_err(stack_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, s, j, input logic [15:0] ja, input logic b,
                      input logic [15:0] bo, input logic c, rt);
    logic [15:0] exp_pc;
    logic exp_err;
    @(negedge clk);
    {rst, stall, jump_en, jump_addr, branch_en, branch_off, call_en, ret_en} = {r, s, j, ja, b, bo, c, rt};
    exp_err = 1'b0;
    if (r) begin
      exp_pc = 16'h0000;
      m_rq.delete();
    end else if (s) exp_pc = m_pc;
    else if (RS && rt) begin
      if (m_rq.size() > 0) exp_pc = m_rq.pop_back();
      else begin
        exp_pc = m_pc + 16'd1;
        exp_err = 1'b1;
      end
    end else if (c) begin
      if (RS && m_rq.size() < 4) m_rq.push_back(m_pc + 16'd1);
      else if (RS) exp_err = 1'b1;
      exp_pc = ja;
    end else if (j) exp_pc = ja;
    else if (b) exp_pc = m_pc + bo;
    else exp_pc = m_pc + 16'd1;
    #1 check("next_pc", 32'(next_pc), 32'(exp_pc));
    @(posedge clk);
    #1;
    m_pc = exp_pc;
    check("pc", 32'(pc), 32'(exp_pc));
    check("stack_err", 32'(stack_err), 32'(exp_err));
    check("stack_full", 32'(stack_full), 32'(RS && m_rq.size() == 4));
    check("stack_empty", 32'(stack_empty), 32'(!RS || m_rq.size() == 0));
  endtask
  task automatic idle();
    step(0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
  endtask
  task automatic jump(input logic [15:0] a);
    step(0, 0, 1, a, 0, 16'h0, 0, 0);
  endtask
  task automatic call(input logic [15:0] a);
    step(0, 0, 0, a, 0, 16'h0, 1, 0);
  endtask
  task automatic ret();
    step(0, 0, 0, 16'h0, 0, 16'h0, 0, 1);
  endtask
  initial begin
    {rst, stall, jump_en, jump_addr, branch_en, branch_off, call_en, ret_en} = '0;
    m_pc = 16'h0;
    step(1, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    check("reset_pc", 32'(pc), 32'h0);
    check("reset_empty", 32'(stack_empty), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      idle();
      check("inc_seq", 32'(pc), 32'(i));
    end
    repeat (2) step(0, 1, 1, 16'h1234, 0, 16'h0, 0, 0);
    check("stall_hold", 32'(pc), 32'h3);
    jump(16'h0010);
    step(0, 0, 0, 16'h0, 1, 16'hFFF8, 0, 0);
    check("branch_neg", 32'(pc), 32'h0008);
    jump(16'hFFFF);
    idle();
    check("inc_wrap", 32'(pc), 32'h0000);
    jump(16'h0020);
    call(16'h0100);
    check("call_target", 32'(pc), 32'h0100);
    ret();
`ifdef PC_RET_STACK_EN
    check("ret_addr", 32'(pc), 32'h0021);
`else
    check("ret_ignored", 32'(pc), 32'h0101);
`endif
    for (int i = 0; i < 4; i++) call(16'h0200 + 16'(i * 16));
    call(16'h0300);
    check("call_full_target", 32'(pc), 32'h0300);
`ifdef PC_RET_STACK_EN
    check("overflow_err", 32'(stack_err), 32'h1);
`endif
    idle();
    check("err_one_cycle", 32'(stack_err), 32'h0);
    repeat (5) ret();
`ifdef PC_RET_STACK_EN
    check("underflow_err", 32'(stack_err), 32'h1);
`endif
    step(0, 0, 1, 16'h0040, 1, 16'h0004, 1, 0);
    check("call_priority", 32'(pc), 32'h0040);
    step(0, 0, 1, 16'h0040, 1, 16'h0004, 1, 0);
    step(0, 0, 0, 16'h0080, 0, 16'h0, 1, 0);
    step(1, 0, 0, 16'h0080, 0, 16'h0, 1, 1);
    check("rst_over_call", 32'(pc), 32'h0);
    check("rst_empty", 32'(stack_empty), 32'h1);
    for (int i = 0; i < 600; i++) begin
      int k;
      k = $urandom_range(0, 99);
      step(k < 2, k >= 2 && k < 10, $urandom_range(0, 3) == 0, 16'($urandom),
           $urandom_range(0, 2) == 0, 16'($urandom), k >= 10 && k < 35, k >= 35 && k < 60);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
